ram_req_bridge: RTL and testbench
=================================

# ram_req_bridge

Target-side bridge for the SRAM-style RAM strobe interface (`ram_a`, `ram_dq_i`/`ram_dq_o`, `ram_cen`/`ram_oen`/`ram_wen`, `data_valid`) driven by the memory controller. It converts each strobe-framed 64-bit access into a single 128-bit MIG user-interface command and returns read data with a level `data_valid`. It replaces the strobe decode inside the DDR wrapper and runs entirely in the MIG user-clock domain.

## Interface
- `ADDR_W`, 26: RAM word address width; one word is 64 bits.
- `APP_ADDR_W`, 28: MIG `app_addr` width.
- `TIMEOUT`, 1023: cycle limit waiting on any `app_*` handshake.

Ports:
- `clk_100MHz` in 1: single clock, the MIG `ui_clk`.
- `rst` in 1: synchronous, active-high reset.
- `ram_a` in `ADDR_W`: word address.
- `ram_dq_i` in 64: write data.
- `ram_dq_o` out 64: read data, held until the next read completes.
- `ram_cen`, `ram_oen`, `ram_wen` in 1 each: active-low strobes.
- `data_valid` out 1: access complete, level signal.
- `busy` out 1: a transaction is in flight.
- `err_timeout` out 1: sticky timeout flag.
- `init_calib_complete` in 1: MIG calibration done.
- `app_addr` out `APP_ADDR_W`; `app_cmd` out 3; `app_en` out 1; `app_rdy` in 1.
- `app_wdf_data` out 128; `app_wdf_mask` out 16; `app_wdf_wren`, `app_wdf_end` out 1; `app_wdf_rdy` in 1.
- `app_rd_data` in 128; `app_rd_data_valid` in 1.

## Operation
- **Request:** a falling edge of `ram_cen` against its registered previous value. Edge → `DECODE`.
- **Strobe skew:** `ram_wen` lags `ram_cen` by one cycle. Access type is sampled in `DECODE`, never on the edge cycle.
  - `ram_wen`=0 → write.
  - `ram_oen`=0 and `ram_wen`=1 → read.
  - Otherwise → `IDLE`, with no app activity.
- **Calibration stall:** `DECODE` holds while `init_calib_complete`=0. The timeout counter does not run during this stall.
- **Address and lane mapping:** `app_addr` = {`ram_a`[25:1], 3'b000}, zero-extended. `ram_a`[0] selects the lane.
  - Lane 0: `app_wdf_data` = {64'h0, `ram_dq_i`}, mask 16'hFF00; read returns `app_rd_data`[63:0].
  - Lane 1: `app_wdf_data` = {`ram_dq_i`, 64'h0}, mask 16'h00FF; read returns `app_rd_data`[127:64].
  - The lane, address and write data are captured in `DECODE`.
- **States:**
  - `IDLE`
  - `DECODE`
  - `WR_ISSUE`: `app_en`, `app_cmd`=3'b000, `app_wdf_wren`=`app_wdf_end`=1. Each drops independently after its own ready handshake. Both accepted → `DONE`.
  - `RD_ISSUE`: `app_en`, `app_cmd`=3'b001, held until `app_rdy` → `RD_WAIT`.
  - `RD_WAIT`: on `app_rd_data_valid`, latch the selected lane into `ram_dq_o` → `DONE`.
  - `DONE`: `data_valid`=1 until `ram_cen` reads 1 → `IDLE`.
  - `DRAIN`
- **Abort:** `ram_cen` rising in `WR_ISSUE`, `RD_ISSUE` or `RD_WAIT` → `DRAIN`.
  - The outstanding handshakes and read return are still completed.
  - Read data is discarded and `data_valid` is not raised; then → `IDLE`.
- **Pending request:** a `ram_cen` falling edge while not in `IDLE` sets a one-deep pending flag. Leaving `DONE` or `DRAIN` with the flag set goes straight to `DECODE` and clears the flag.
- **Timeout:** more than `TIMEOUT` cycles in `WR_ISSUE`, `RD_ISSUE` or `RD_WAIT` →
  - set `err_timeout`;
  - deassert all `app_*` strobes;
  - for a read, set `ram_dq_o`=0;
  - go to `DONE` so the initiator never hangs.
- `err_timeout` clears only on `rst`.
- `busy` = (state ≠ `IDLE`).

## Timing
- **Reset values:** `app_en`, `app_wdf_wren`, `app_wdf_end`, `data_valid`, `busy`, `err_timeout` = 0; `app_cmd`=3'b000; `app_addr`=0; `app_wdf_data`=0; `app_wdf_mask`=16'hFFFF; `ram_dq_o`=0; pending flag = 0.
- **Read, minimum latency** (ready asserted, `app_rd_data_valid` at N): `ram_cen` falls at T; `DECODE` at T+1; `app_en` at T+2; `data_valid` at N+1.
- **Write, minimum latency:** both readies high → `data_valid` at T+3.
- **Reset mid-transaction:** all outputs return to reset values on the next edge. No `DRAIN` is performed.
- **Simultaneous events:**
  - `ram_cen` rise in the same cycle as `app_rd_data_valid` counts as an abort: data is discarded.
  - Timeout and handshake in the same cycle: the handshake wins.

## Structure
- **Package `ram_bridge_pkg`:**
  - state enum;
  - `CMD_WRITE`=3'b000 and `CMD_READ`=3'b001;
  - lane masks 16'hFF00 and 16'h00FF;
  - the lane data-select function.
- **Sub-module `ram_bridge_timer`:** saturating counter with clear and enable inputs, and a `expired` output driven when the count exceeds `TIMEOUT`.

## Test plan
- **Lane-1 write:** `ram_a`=26'h0000005, `ram_dq_i`=64'h00AB_CDEF_0123_4567 → `app_addr`=28'h0000010, mask 16'h00FF, data in the upper half; `data_valid` at T+3.
- **Lane-0 read:** `ram_a`=26'h4; `app_rd_data`={64'h1111, 64'h2222} after 7 cycles → `ram_dq_o`=64'h2222; `data_valid` held until `ram_cen`=1.
- **Write-ready skew:** `app_rdy`=0 for 5 cycles, `app_wdf_rdy`=1 → data beat accepted at T+2; `app_en` held 5 more cycles; single write issued.
- **Abort:** `ram_cen` rises in `RD_WAIT`, followed by a new falling edge → read data discarded, no `data_valid` for it; second request serviced right after the drain.
- **Timeout:** `app_rdy` stuck at 0 → after 1024 cycles, `err_timeout`=1, `ram_dq_o`=0, `data_valid`=1.
- **Calibration and reset:** `init_calib_complete`=0 → request stalls in `DECODE` with no timeout. Assert `rst` during `RD_ISSUE` → all outputs at reset values next cycle.

Source files
------------

// File: rtl/ram_bridge_pkg.sv
// Shared types and constants for the RAM strobe to MIG bridge.
package ram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WR_ISSUE = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DONE     = 3'd5,
    ST_DRAIN    = 3'd6
  } state_e;

  localparam logic [2:0]  CMD_WRITE  = 3'b000;
  localparam logic [2:0]  CMD_READ   = 3'b001;

  // A set mask bit blocks that byte, so each lane masks the other half.
  localparam logic [15:0] MASK_LANE0 = 16'hFF00;
  localparam logic [15:0] MASK_LANE1 = 16'h00FF;

  // Pick the 64-bit word of a 128-bit MIG beat addressed by the lane bit.
  function automatic logic [63:0] lane_sel(input logic [127:0] data, input logic lane);
    return lane ? data[127:64] : data[63:0];
  endfunction

endpackage

// File: rtl/ram_bridge_timer.sv
// Saturating cycle counter guarding the app_* handshakes.
module ram_bridge_timer
  import ram_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 2) + 1;

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, stick at all-ones so a long hang cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q > CNT_W'(TIMEOUT));

endmodule

// File: rtl/ram_req_bridge.sv
// Strobe-framed 64-bit RAM access to single 128-bit MIG command bridge.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a ram_cen falling edge
// DECODE    | sample access type, address, lane, data (stalls w/o calib)
// WR_ISSUE  | app_en and wdf strobes up, each drops on its own ready
// RD_ISSUE  | app_en with read command until app_rdy
// RD_WAIT   | waiting for app_rd_data_valid
// DONE      | data_valid high until ram_cen returns high
// DRAIN     | initiator aborted; finish outstanding handshakes silently
module ram_req_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int APP_ADDR_W = 28,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ram_a,
  input  logic [63:0]           ram_dq_i,
  output logic [63:0]           ram_dq_o,
  input  logic                  ram_cen,
  input  logic                  ram_oen,
  input  logic                  ram_wen,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  init_calib_complete,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [127:0]          app_wdf_data,
  output logic [15:0]           app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [127:0]          app_rd_data,
  input  logic                  app_rd_data_valid
);

  state_e                  state_q, state_d;
  logic                    cen_q;
  logic                    pend_q, pend_d;
  logic                    lane_q, lane_d;
  logic                    rd_out_q, rd_out_d;
  logic                    app_en_q, app_en_d;
  logic                    wren_q, wren_d;
  logic                    wend_q, wend_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [APP_ADDR_W-1:0]   addr_q, addr_d;
  logic [127:0]            wdata_q, wdata_d;
  logic [15:0]             wmask_q, wmask_d;
  logic [63:0]             dq_q, dq_d;
  logic                    err_q, err_d;

  logic cen_fall, cen_rise, timed, expired, rd_accept;

  assign cen_fall  = cen_q & ~ram_cen;
  assign cen_rise  = ~cen_q & ram_cen;
  assign timed     = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE) ||
                     (state_q == ST_RD_WAIT)  || (state_q == ST_DRAIN);
  assign rd_accept = app_en_q & app_rdy & (cmd_q == CMD_READ);

  ram_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_100MHz),
    .rst_i   (rst),
    .clr_i   (~timed),
    .en_i    (timed),
    .expired (expired)
  );

  // Next-state and output-register logic; strobes drop on their own handshake by default.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | (cen_fall & (state_q != ST_IDLE));
    lane_d   = lane_q;
    rd_out_d = (rd_out_q | rd_accept) & ~app_rd_data_valid;
    app_en_d = app_en_q & ~app_rdy;
    wren_d   = wren_q & ~app_wdf_rdy;
    wend_d   = wend_q & ~app_wdf_rdy;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    dq_d     = dq_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cen_fall) state_d = ST_DECODE;
      end

      // ram_wen lags ram_cen, so the access type is only trusted here.
      ST_DECODE: begin
        if (init_calib_complete) begin
          if (!ram_wen) begin
            state_d  = ST_WR_ISSUE;
            lane_d   = ram_a[0];
            addr_d   = APP_ADDR_W'({ram_a[ADDR_W-1:1], 3'b000});
            cmd_d    = CMD_WRITE;
            app_en_d = 1'b1;
            wren_d   = 1'b1;
            wend_d   = 1'b1;
            wdata_d  = ram_a[0] ? {ram_dq_i, 64'h0} : {64'h0, ram_dq_i};
            wmask_d  = ram_a[0] ? MASK_LANE1 : MASK_LANE0;
          end else if (!ram_oen) begin
            state_d  = ST_RD_ISSUE;
            lane_d   = ram_a[0];
            addr_d   = APP_ADDR_W'({ram_a[ADDR_W-1:1], 3'b000});
            cmd_d    = CMD_READ;
            app_en_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end

      ST_WR_ISSUE: begin
        if (cen_rise) begin
          state_d = ST_DRAIN;
        end else if (!app_en_d && !wren_d) begin
          state_d = ST_DONE;
        end else if (expired) begin
          app_en_d = 1'b0;
          wren_d   = 1'b0;
          wend_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_RD_ISSUE: begin
        if (cen_rise) begin
          state_d = ST_DRAIN;
        end else if (app_rdy) begin
          state_d = ST_RD_WAIT;
        end else if (expired) begin
          app_en_d = 1'b0;
          err_d    = 1'b1;
          dq_d     = '0;
          state_d  = ST_DONE;
        end
      end

      // An abort coinciding with the returning beat still discards it.
      ST_RD_WAIT: begin
        if (cen_rise) begin
          state_d = ST_DRAIN;
        end else if (app_rd_data_valid) begin
          dq_d    = lane_sel(app_rd_data, lane_q);
          state_d = ST_DONE;
        end else if (expired) begin
          rd_out_d = 1'b0;
          err_d    = 1'b1;
          dq_d     = '0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (ram_cen) begin
          state_d = pend_q ? ST_DECODE : ST_IDLE;
          pend_d  = 1'b0;
        end
      end

      // A MIG that never answers would otherwise park us here forever.
      ST_DRAIN: begin
        if (!app_en_d && !wren_d && !rd_out_d) begin
          state_d = (pend_q || cen_fall) ? ST_DECODE : ST_IDLE;
          pend_d  = 1'b0;
        end else if (expired) begin
          app_en_d = 1'b0;
          wren_d   = 1'b0;
          wend_d   = 1'b0;
          rd_out_d = 1'b0;
          err_d    = 1'b1;
          state_d  = (pend_q || cen_fall) ? ST_DECODE : ST_IDLE;
          pend_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops everything without draining.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cen_q    <= 1'b1;
      pend_q   <= 1'b0;
      lane_q   <= 1'b0;
      rd_out_q <= 1'b0;
      app_en_q <= 1'b0;
      wren_q   <= 1'b0;
      wend_q   <= 1'b0;
      cmd_q    <= CMD_WRITE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= 16'hFFFF;
      dq_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cen_q    <= ram_cen;
      pend_q   <= pend_d;
      lane_q   <= lane_d;
      rd_out_q <= rd_out_d;
      app_en_q <= app_en_d;
      wren_q   <= wren_d;
      wend_q   <= wend_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      dq_q     <= dq_d;
      err_q    <= err_d;
    end
  end

  assign data_valid   = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign err_timeout  = err_q;
  assign ram_dq_o     = dq_q;
  assign app_addr     = addr_q;
  assign app_cmd      = cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = wmask_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wend_q;

endmodule

// File: tb/tb_ram_req_bridge.sv
// Directed bench for ram_req_bridge with hand-computed expectations.
module tb_ram_req_bridge;

  logic         clk_100MHz = 1'b0;
  logic         rst;
  logic [25:0]  ram_a;
  logic [63:0]  ram_dq_i, ram_dq_o;
  logic         ram_cen, ram_oen, ram_wen;
  logic         data_valid, busy, err_timeout, init_calib_complete;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cmds = 0, rd_cmds = 0, wdf_beats = 0;
  int wr0, rd0, b0, n_en;

  always #5 clk_100MHz = ~clk_100MHz;

  ram_req_bridge dut (
    .clk_100MHz          (clk_100MHz),
    .rst                 (rst),
    .ram_a               (ram_a),
    .ram_dq_i            (ram_dq_i),
    .ram_dq_o            (ram_dq_o),
    .ram_cen             (ram_cen),
    .ram_oen             (ram_oen),
    .ram_wen             (ram_wen),
    .data_valid          (data_valid),
    .busy                (busy),
    .err_timeout         (err_timeout),
    .init_calib_complete (init_calib_complete),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid)
  );

  // Count accepted handshakes as the MIG would see them.
  always @(posedge clk_100MHz) begin
    if (!rst) begin
      if (app_en && app_rdy && app_cmd == 3'b000) wr_cmds = wr_cmds + 1;
      if (app_en && app_rdy && app_cmd == 3'b001) rd_cmds = rd_cmds + 1;
      if (app_wdf_wren && app_wdf_rdy)            wdf_beats = wdf_beats + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_app_en"},   app_en, 1'b0);
    check({pfx, "_wren"},     app_wdf_wren, 1'b0);
    check({pfx, "_wend"},     app_wdf_end, 1'b0);
    check({pfx, "_dv"},       data_valid, 1'b0);
    check({pfx, "_busy"},     busy, 1'b0);
    check({pfx, "_err"},      err_timeout, 1'b0);
    check({pfx, "_cmd"},      app_cmd, 3'b000);
    check({pfx, "_addr"},     app_addr, 28'h0);
    check({pfx, "_wdata"},    app_wdf_data, 128'h0);
    check({pfx, "_mask"},     app_wdf_mask, 16'hFFFF);
    check({pfx, "_dq"},       ram_dq_o, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ram_cen = 1'b1; ram_oen = 1'b1; ram_wen = 1'b1;
    ram_a = '0; ram_dq_i = '0; init_calib_complete = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
    step(); step();
    check_reset("rst0");
    rst = 1'b0;
    step();

    // Lane-1 write, minimum latency
    wr0 = wr_cmds; b0 = wdf_beats;
    ram_a = 26'h0000005; ram_dq_i = 64'h00AB_CDEF_0123_4567; ram_cen = 1'b0;
    step();
    check("wr1_dec_busy", busy, 1'b1);
    check("wr1_dec_en", app_en, 1'b0);
    ram_wen = 1'b0;
    step();
    check("wr1_en", app_en, 1'b1);
    check("wr1_cmd", app_cmd, 3'b000);
    check("wr1_wren", app_wdf_wren, 1'b1);
    check("wr1_wend", app_wdf_end, 1'b1);
    check("wr1_addr", app_addr, 28'h0000010);
    check("wr1_mask", app_wdf_mask, 16'h00FF);
    check("wr1_data", app_wdf_data, {64'h00AB_CDEF_0123_4567, 64'h0});
    check("wr1_dv_early", data_valid, 1'b0);
    step();
    check("wr1_dv", data_valid, 1'b1);
    check("wr1_en_drop", app_en, 1'b0);
    check("wr1_wren_drop", app_wdf_wren, 1'b0);
    check("wr1_ncmd", wr_cmds - wr0, 1);
    check("wr1_nbeat", wdf_beats - b0, 1);
    ram_cen = 1'b1; ram_wen = 1'b1;
    step();
    check("wr1_dv_off", data_valid, 1'b0);
    check("wr1_idle", busy, 1'b0);

    // Lane-0 read, data returns 7 cycles after app_en
    rd0 = rd_cmds;
    ram_a = 26'h4; ram_cen = 1'b0; ram_oen = 1'b0;
    step();
    step();
    check("rd0_en", app_en, 1'b1);
    check("rd0_cmd", app_cmd, 3'b001);
    check("rd0_addr", app_addr, 28'h0000010);
    check("rd0_wren", app_wdf_wren, 1'b0);
    step();
    check("rd0_en_drop", app_en, 1'b0);
    repeat (6) step();
    check("rd0_dv_early", data_valid, 1'b0);
    app_rd_data = {64'h1111, 64'h2222}; app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0; app_rd_data = '1;
    check("rd0_dv", data_valid, 1'b1);
    check("rd0_dq", ram_dq_o, 64'h2222);
    repeat (3) step();
    check("rd0_dv_hold", data_valid, 1'b1);
    check("rd0_dq_hold", ram_dq_o, 64'h2222);
    ram_cen = 1'b1; ram_oen = 1'b1;
    step();
    check("rd0_dv_off", data_valid, 1'b0);
    check("rd0_dq_kept", ram_dq_o, 64'h2222);
    check("rd0_ncmd", rd_cmds - rd0, 1);

    // Write with app_rdy skewed behind app_wdf_rdy
    wr0 = wr_cmds; b0 = wdf_beats;
    ram_a = 26'h0; ram_dq_i = 64'hDEAD_BEEF_CAFE_F00D; app_rdy = 1'b0; ram_cen = 1'b0;
    step();
    ram_wen = 1'b0;
    step();
    check("skw_en", app_en, 1'b1);
    check("skw_wren", app_wdf_wren, 1'b1);
    check("skw_mask", app_wdf_mask, 16'hFF00);
    check("skw_data", app_wdf_data, {64'h0, 64'hDEAD_BEEF_CAFE_F00D});
    step();
    check("skw_wren_drop", app_wdf_wren, 1'b0);
    check("skw_en_hold", app_en, 1'b1);
    repeat (4) step();
    check("skw_en_hold5", app_en, 1'b1);
    check("skw_dv_early", data_valid, 1'b0);
    app_rdy = 1'b1;
    step();
    check("skw_dv", data_valid, 1'b1);
    check("skw_en_drop", app_en, 1'b0);
    check("skw_ncmd", wr_cmds - wr0, 1);
    check("skw_nbeat", wdf_beats - b0, 1);
    ram_cen = 1'b1; ram_wen = 1'b1;
    step();

    // Abort in RD_WAIT with a second request queued during the drain
    rd0 = rd_cmds; wr0 = wr_cmds;
    ram_a = 26'h7; ram_cen = 1'b0; ram_oen = 1'b0;
    step();
    step();
    step();
    check("ab_wait_en", app_en, 1'b0);
    ram_cen = 1'b1; ram_oen = 1'b1;
    step();
    check("ab_drain_busy", busy, 1'b1);
    check("ab_drain_dv", data_valid, 1'b0);
    ram_cen = 1'b0; ram_a = 26'h6; ram_dq_i = 64'hFEED_0000_0000_BEEF;
    step();
    check("ab_drain2_dv", data_valid, 1'b0);
    check("ab_drain2_en", app_en, 1'b0);
    ram_wen = 1'b0;
    app_rd_data = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}; app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
    check("ab_dec_dv", data_valid, 1'b0);
    check("ab_dec_busy", busy, 1'b1);
    check("ab_dq_discard", ram_dq_o, 64'h2222);
    step();
    check("ab_wr_en", app_en, 1'b1);
    check("ab_wr_cmd", app_cmd, 3'b000);
    check("ab_wr_addr", app_addr, 28'h0000018);
    step();
    check("ab_wr_dv", data_valid, 1'b1);
    check("ab_nrd", rd_cmds - rd0, 1);
    check("ab_nwr", wr_cmds - wr0, 1);
    ram_cen = 1'b1; ram_wen = 1'b1;
    step();
    check("ab_idle", busy, 1'b0);

    // Strobe without oen/wen returns to IDLE with no app activity
    rd0 = rd_cmds; wr0 = wr_cmds;
    ram_cen = 1'b0;
    step();
    check("nop_dec", busy, 1'b1);
    step();
    check("nop_idle", busy, 1'b0);
    check("nop_en", app_en, 1'b0);
    ram_cen = 1'b1;
    step();
    check("nop_ncmd", (rd_cmds - rd0) + (wr_cmds - wr0), 0);

    // Timeout with app_rdy stuck low
    app_rdy = 1'b0; ram_a = 26'h9; ram_cen = 1'b0; ram_oen = 1'b0;
    step();
    n_en = 0;
    for (int i = 0; i < 1100 && !err_timeout; i++) begin
      step();
      if (app_en) n_en++;
    end
    check("to_err", err_timeout, 1'b1);
    check("to_cycles_ok", (n_en >= 1024 && n_en <= 1026), 1'b1);
    check("to_dq", ram_dq_o, 64'h0);
    check("to_dv", data_valid, 1'b1);
    check("to_en", app_en, 1'b0);
    ram_cen = 1'b1; ram_oen = 1'b1; app_rdy = 1'b1;
    step();
    check("to_dv_off", data_valid, 1'b0);
    check("to_err_sticky", err_timeout, 1'b1);
    rst = 1'b1;
    step();
    check("to_err_clr", err_timeout, 1'b0);
    rst = 1'b0;
    step();

    // Calibration stall does not time out; then reset during RD_ISSUE
    init_calib_complete = 1'b0;
    ram_a = 26'h3FF_FFFF; ram_cen = 1'b0; ram_oen = 1'b0;
    step();
    repeat (1100) step();
    check("cal_busy", busy, 1'b1);
    check("cal_en", app_en, 1'b0);
    check("cal_err", err_timeout, 1'b0);
    init_calib_complete = 1'b1; app_rdy = 1'b0;
    step();
    check("cal_en_go", app_en, 1'b1);
    check("cal_addr", app_addr, 28'hFFFFFF8);
    rst = 1'b1; ram_cen = 1'b1; ram_oen = 1'b1;
    step();
    check_reset("rst1");
    rst = 1'b0; app_rdy = 1'b1;
    step();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_en", app_en, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
